// File: rtl/mod997_pkg.sv
// mod997_pkg: shared constants, FSM state type and per-chunk LUT constant
// helper for the mod-997 datapath. Residues fit in 10 bits, the operand is
// walked in 6-bit chunks and the constant multiplier is 400.
package mod997_pkg;
  localparam int MOD     = 997;
  localparam int RES_W   = 10;
  localparam int CHUNK_W = 6;
  localparam int MULT    = 400;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Index width for a chunk counter; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // K_i = (2^(CHUNK_W*i) * MULT) mod MOD, built by repeated *64 mod MOD so
  // no intermediate ever overflows 32 bits.
  function automatic logic [RES_W-1:0] chunk_k(input int i);
    int k;
    k = MULT % MOD;
    for (int j = 0; j < i; j++) k = (k * (1 << CHUNK_W)) % MOD;
    return RES_W'(k);
  endfunction
endpackage

// File: rtl/mod997_chunk_seq_if.sv
// mod997_chunk_seq_if: operand/result handshakes plus the shared LUT port.
//   master : operand source, result consumer and LUT bank (drives in_*,
//            out_ready, lut_data)
//   slave  : the chunk sequencer
interface mod997_chunk_seq_if #(parameter int N_CHUNK = 4);
  import mod997_pkg::*;
  localparam int IDX_W = idx_w(N_CHUNK);

  logic                         in_valid;
  logic                         in_ready;
  logic [CHUNK_W*N_CHUNK-1:0]   in_data;
  logic [IDX_W-1:0]             lut_idx;
  logic [CHUNK_W-1:0]           lut_chunk;
  logic [RES_W-1:0]             lut_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [RES_W-1:0]             out_data;
  logic                         lut_err;

  modport master (
    output in_valid, in_data, out_ready, lut_data,
    input  in_ready, lut_idx, lut_chunk, out_valid, out_data, lut_err
  );
  modport slave (
    input  in_valid, in_data, out_ready, lut_data,
    output in_ready, lut_idx, lut_chunk, out_valid, out_data, lut_err
  );
endinterface

// File: rtl/mod997_add.sv
// mod997_add: combinational modulo-997 adder.
//   a, b : addends (normally < 997)
//   y    : (a + b) mod 997 using a single conditional subtract; with
//          out-of-range inputs the result is just the truncated value.
module mod997_add
  import mod997_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] y
);
  localparam logic [RES_W:0] M = (RES_W+1)'(MOD);

  logic [RES_W:0] s;

  assign s = {1'b0, a} + {1'b0, b};
  assign y = (s >= M) ? RES_W'(s - M) : RES_W'(s);
endmodule

// File: rtl/mod997_chunk_seq.sv
// mod997_chunk_seq: computes (X * 400) mod 997 by presenting one 6-bit chunk
// of X per cycle to an external residue LUT and accumulating the returned
// residues with mod997_add.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mod997_chunk_seq_if
//              in_valid/in_ready/in_data    operand handshake
//              lut_idx/lut_chunk/lut_data   shared LUT port (same-cycle data)
//              out_valid/out_ready/out_data result handshake
//              lut_err                      sticky out-of-range LUT flag
module mod997_chunk_seq
  import mod997_pkg::*;
#(
  parameter int N_CHUNK = 4
) (
  input  logic clk,
  input  logic rst,
  mod997_chunk_seq_if.slave bus
);
  localparam int               IDX_W = idx_w(N_CHUNK);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_CHUNK - 1);

  state_t                           state;
  logic [N_CHUNK-1:0][CHUNK_W-1:0]  op;
  logic [IDX_W-1:0]                 cnt;
  logic [RES_W-1:0]                 acc;
  logic [RES_W-1:0]                 sum;
  logic                             in_ready_q;
  logic                             out_valid_q;
  logic [RES_W-1:0]                 out_data_q;
  logic                             lut_err_q;

  mod997_add u_add (.a(acc), .b(bus.lut_data), .y(sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op          <= '0;
      cnt         <= '0;
      acc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      lut_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op         <= bus.in_data;
          cnt        <= '0;
          acc        <= '0;
          in_ready_q <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (bus.lut_data >= RES_W'(MOD)) lut_err_q <= 1'b1;
          // Last chunk: the final sum goes straight to the output register
          // so out_data equals acc for the whole DONE stay.
          if (cnt == LAST) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sum;
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.lut_err   = lut_err_q;
  // LUT port is decoded from registered state so it settles early in RUN.
  assign bus.lut_idx   = (state == RUN) ? cnt     : '0;
  assign bus.lut_chunk = (state == RUN) ? op[cnt] : '0;
endmodule

// File: tb/tb_mod997_chunk_seq.sv
// tb_mod997_chunk_seq: scoreboard bench for mod997_chunk_seq with a
// behavioural LUT bank and an arithmetic reference model.
module tb_mod997_chunk_seq;
  import mod997_pkg::*;

  localparam int N_CHUNK = 4;
  localparam int OP_W    = CHUNK_W * N_CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod997_chunk_seq_if #(.N_CHUNK(N_CHUNK)) bus();
  mod997_chunk_seq #(.N_CHUNK(N_CHUNK)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];        // -1 marks a result whose value is not checked
  bit force_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_mod(input longint x);
    return int'((x * MULT) % MOD);
  endfunction

  // Behavioural LUT bank: table i returns (c * K_i) mod 997.
  always_comb begin
    int t;
    t = (int'(bus.lut_chunk) * int'(chunk_k(int'(bus.lut_idx)))) % MOD;
    if (force_err && bus.lut_idx == 2) t = 1000;
    bus.lut_data = RES_W'(t);
  end

  // Monitor: pops the scoreboard on every result handshake and checks that a
  // stalled result stays put.
  int               mon_e;
  bit               holding = 1'b0;
  logic [RES_W-1:0] held;
  always @(negedge clk) begin
    if (rst) holding = 1'b0;
    else begin
      if (holding) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d, expected no result", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e >= 0) check("result", bus.out_data, mon_e);
        end
      end
      holding = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
    end
  end

  // Offer x; returns #1 after the accept edge. Call away from the clock edge.
  task automatic send(input logic [OP_W-1:0] x, input int expv, input bit lat);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = bus.in_ready;
      if (!ok) begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(expv);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = OP_W'($urandom);
    if (lat)
      for (int k = 1; k <= N_CHUNK + 1; k++) begin
        @(negedge clk);
        check("latency_out_valid", bus.out_valid, (k == N_CHUNK + 1) ? 1 : 0);
      end
  endtask

  // Wait for the sequencer to return to IDLE, optionally jittering out_ready.
  task automatic drain(input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      else     bus.out_ready = 1'b1;
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got in_ready=0, expected 1");
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  logic [OP_W-1:0] dir_x [6] = '{24'd1, 24'd64, 24'd997, 24'd998, 24'd0, 24'hFFFFFF};
  int              dir_e [6] = '{400, 675, 0, 400, 0, 237};

  initial begin
    logic [OP_W-1:0] x;
    bit              seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_lut_idx", bus.lut_idx, 0);
    check("rst_lut_chunk", bus.lut_chunk, 0);
    check("rst_lut_err", bus.lut_err, 0);

    // Directed operands; the first also checks accept-to-valid latency.
    for (int i = 0; i < 6; i++) begin
      send(dir_x[i], dir_e[i], i == 0);
      drain(1'b0);
    end

    // Backpressure: hold the result 7 cycles, then a back-to-back operand.
    @(posedge clk); #1 bus.out_ready = 1'b0;
    x = 24'h123456;
    send(x, ref_mod(x), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("bp_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_out_data", bus.out_data, ref_mod(x));
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_release_out_valid", bus.out_valid, 0);
    send(24'd2, 800, 1'b0);
    drain(1'b0);

    // Reset on the second RUN cycle discards the operation.
    send(24'h00ABCD, ref_mod(24'h00ABCD), 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_lut_idx", bus.lut_idx, 0);
    send(24'd1, 400, 1'b1);
    drain(1'b0);

    // Randomized operands with random consumer stalls.
    for (int i = 0; i < 20; i++) begin
      x = OP_W'($urandom);
      send(x, ref_mod(x), 1'b0);
      drain(1'b1);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("err_clear_before", bus.lut_err, 0);

    // Out-of-range LUT value: sticky flag until reset.
    force_err = 1'b1;
    send(24'hFFFFFF, -1, 1'b0);
    drain(1'b0);
    force_err = 1'b0;
    check("err_set", bus.lut_err, 1);
    x = 24'h0BEEF5;
    send(x, ref_mod(x), 1'b0);
    drain(1'b0);
    check("err_sticky", bus.lut_err, 1);
    pulse_rst();
    @(negedge clk);
    check("err_cleared_by_rst", bus.lut_err, 0);
    send(24'd998, 400, 1'b0);
    drain(1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
